// File: rtl/data_memory_responder.sv
// Word-addressed data memory behind a three-state request/response handshake.
// A request is accepted in IDLE and answered LATENCY cycles later with a one-cycle response.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        resp_valid,
    output logic        stall,
    output logic        error
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_is_read;
    logic        r_is_write;
    logic [31:0] r_read_data;
    logic        r_error;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_req;
    logic          w_accept;
    logic          w_enter_done;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic          w_is_read;
    logic          w_is_write;
    logic          w_in_range;
    logic          w_aligned;
    logic          w_conflict;
    logic          w_error;
    logic          w_do_write;
    logic [AW-1:0] w_index;

    assign w_req        = mem_read | mem_write;
    assign w_accept     = (r_state == IDLE) && w_req;
    assign w_enter_done = (w_accept && (LATENCY == 1)) ||
                          ((r_state == WAIT) && (r_count == 4'd1));

    // With LATENCY=1 DONE is entered straight from IDLE, before anything is latched.
    assign w_addr     = (r_state == IDLE) ? address    : r_addr;
    assign w_wdata    = (r_state == IDLE) ? write_data : r_wdata;
    assign w_is_read  = (r_state == IDLE) ? mem_read   : r_is_read;
    assign w_is_write = (r_state == IDLE) ? mem_write  : r_is_write;

    assign w_in_range = {2'b00, w_addr[31:2]} < 32'(DEPTH_WORDS);
    assign w_aligned  = (w_addr[1:0] == 2'b00);
    assign w_conflict = w_is_read & w_is_write;
    assign w_error    = ~w_aligned | ~w_in_range | w_conflict;
    assign w_index    = w_addr[AW+1:2];
    assign w_do_write = w_enter_done & w_is_write & ~w_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    stall        = 1'b1;
                    w_next_state = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (r_count == 4'd1) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                resp_valid   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_is_read   <= 1'b0;
            r_is_write  <= 1'b0;
            r_read_data <= 32'd0;
            r_error     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= address;
                r_wdata    <= write_data;
                r_is_read  <= mem_read;
                r_is_write <= mem_write;
                r_count    <= LAT_M1;
            end else if (r_state == WAIT) begin
                r_count <= r_count - 4'd1;
            end
            // Response fields live only for the DONE cycle and drop back to zero after it.
            if (w_enter_done) begin
                r_error     <= w_error;
                r_read_data <= (w_is_read && !w_error) ? r_mem[w_index] : 32'd0;
            end else begin
                r_error     <= 1'b0;
                r_read_data <= 32'd0;
            end
        end
    end

    // Storage has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_index] <= w_wdata;
        end
    end

    assign read_data = r_read_data;
    assign error     = r_error;

endmodule
